// File: rtl/fetch_unit.sv
// MINAv2 instruction-address and fetch stages with the IF/ID register.
// Credit-limited in-order fetch into a small buffer, with redirect flush and load-hazard hold.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        load_hazard,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = $clog2(BUF_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] occupancy;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   fifo_instr [BUF_DEPTH];
    logic [31:0]   fifo_pc    [BUF_DEPTH];
    logic [CW:0]   credits_used;
    logic          accept;
    logic          push;
    logic          pop;

    // Words in flight plus words already buffered may never exceed the buffer size.
    assign credits_used   = {1'b0, outstanding} + {1'b0, occupancy};
    assign imem_req_valid = !rst && !redirect_valid && (credits_used < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pc;

    assign accept = imem_req_valid && imem_req_ready;
    assign push   = imem_rsp_valid && !redirect_valid && (discard == '0);
    assign pop    = !redirect_valid && !load_hazard && (occupancy != '0);

    always_comb begin
        outstanding_next = outstanding;
        if (accept && !imem_rsp_valid) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!accept && imem_rsp_valid) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                pc        <= redirect_pc;
                rsp_pc    <= redirect_pc;
                discard   <= outstanding_next;
                occupancy <= '0;
                head      <= '0;
                tail      <= '0;
                if_valid  <= 1'b0;
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    tail   <= tail + PW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (!load_hazard) begin
                    if (occupancy != '0) begin
                        if_instr <= fifo_instr[head];
                        if_pc    <= fifo_pc[head];
                        head     <= head + PW'(1);
                        if_valid <= 1'b1;
                    end else begin
                        if_valid <= 1'b0;
                    end
                end
                case ({push, pop})
                    2'b10:   occupancy <= occupancy + CW'(1);
                    2'b01:   occupancy <= occupancy - CW'(1);
                    default: occupancy <= occupancy;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[tail] <= imem_rsp_data;
            fifo_pc[tail]    <= rsp_pc;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (push && !pop) |-> (occupancy < CW'(BUF_DEPTH)));

endmodule
